// File: rtl/ar_multiport_request_buffer.sv
// Multi-port AR ingress buffer: per-port FIFOs feed one registered AR output.
// Arbitration picks the highest head QoS first, with a round-robin tie-break.
module ar_multiport_request_buffer #(
   parameter int NUM_IN     = 4,
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 8,
   parameter int TAG_WIDTH  = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int QOS_EN     = 1,
   localparam int SRC_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_IN-1:0]            in_valid,
   output logic [NUM_IN-1:0]            in_ready,
   input  logic [NUM_IN*ID_WIDTH-1:0]   in_id,
   input  logic [NUM_IN*ADDR_WIDTH-1:0] in_addr,
   input  logic [NUM_IN*LEN_WIDTH-1:0]  in_len,
   input  logic [NUM_IN*3-1:0]          in_size,
   input  logic [NUM_IN*2-1:0]          in_burst,
   input  logic [NUM_IN*4-1:0]          in_qos,
   input  logic [NUM_IN*TAG_WIDTH-1:0]  in_tag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ID_WIDTH-1:0]          out_id,
   output logic [ADDR_WIDTH-1:0]        out_addr,
   output logic [LEN_WIDTH-1:0]         out_len,
   output logic [2:0]                   out_size,
   output logic [1:0]                   out_burst,
   output logic [3:0]                   out_qos,
   output logic [TAG_WIDTH-1:0]         out_tag,
   output logic [SRC_W-1:0]             out_src,
   output logic [NUM_IN*CNT_W-1:0]      occ
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int EW    = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 3 + 2 + 4 + TAG_WIDTH;

   // Entry packing: {id, addr, len, size, burst, qos, tag}; qos sits just above tag.
   logic [EW-1:0]     mem_q    [NUM_IN][FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q [NUM_IN];
   logic [PTR_W-1:0]  rd_ptr_q [NUM_IN];
   logic [CNT_W-1:0]  cnt_q    [NUM_IN];
   logic [CNT_W-1:0]  cnt_d    [NUM_IN];
   logic [EW-1:0]     in_entry [NUM_IN];
   logic [EW-1:0]     head     [NUM_IN];
   logic [3:0]        head_qos [NUM_IN];
   logic [NUM_IN-1:0] not_full;
   logic [NUM_IN-1:0] nonempty;
   logic [NUM_IN-1:0] eligible;
   logic [NUM_IN-1:0] push;
   logic [NUM_IN-1:0] pop;
   logic [3:0]        max_qos;
   logic [SRC_W-1:0]  grant;
   logic [SRC_W-1:0]  grant_hi;
   logic [SRC_W-1:0]  grant_lo;
   logic              found_hi;
   logic              found_lo;
   logic [SRC_W-1:0]  rr_ptr_q;
   logic [SRC_W-1:0]  rr_ptr_d;
   logic              any_req;
   logic              can_load;
   logic              load;
   logic              out_valid_q;
   logic [EW-1:0]     out_entry_q;
   logic [SRC_W-1:0]  out_src_q;

   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         in_entry[i] = {in_id[i*ID_WIDTH +: ID_WIDTH], in_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                        in_len[i*LEN_WIDTH +: LEN_WIDTH], in_size[i*3 +: 3],
                        in_burst[i*2 +: 2], in_qos[i*4 +: 4], in_tag[i*TAG_WIDTH +: TAG_WIDTH]};
         head[i]      = mem_q[i][rd_ptr_q[i]];
         head_qos[i]  = head[i][TAG_WIDTH +: 4];
         nonempty[i]  = (cnt_q[i] != '0);
         not_full[i]  = (cnt_q[i] != CNT_W'(FIFO_DEPTH));
         push[i]      = in_valid[i] & not_full[i];
         occ[i*CNT_W +: CNT_W] = cnt_q[i];
      end
   end

   assign in_ready = not_full;

   // Rotating priority: lowest eligible index at/after rr_ptr, else lowest eligible overall.
   always_comb begin
      max_qos = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (nonempty[i] && (head_qos[i] > max_qos)) max_qos = head_qos[i];
      end
      found_hi = 1'b0;
      found_lo = 1'b0;
      grant_hi = '0;
      grant_lo = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         eligible[i] = nonempty[i] && ((QOS_EN == 0) || (head_qos[i] == max_qos));
         if (!found_hi && eligible[i] && (SRC_W'(i) >= rr_ptr_q)) begin
            found_hi = 1'b1;
            grant_hi = SRC_W'(i);
         end
         if (!found_lo && eligible[i]) begin
            found_lo = 1'b1;
            grant_lo = SRC_W'(i);
         end
      end
      grant    = found_hi ? grant_hi : grant_lo;
      rr_ptr_d = (grant == SRC_W'(NUM_IN - 1)) ? '0 : grant + SRC_W'(1);
      any_req  = |nonempty;
      can_load = ~out_valid_q | out_ready;
      load     = can_load & any_req;
      for (int i = 0; i < NUM_IN; i++) begin
         pop[i]   = load && (grant == SRC_W'(i));
         cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_IN; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_entry_q <= '0;
         out_src_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
            if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
            cnt_q[i] <= cnt_d[i];
         end
         if (load) begin
            out_valid_q <= 1'b1;
            out_entry_q <= head[grant];
            out_src_q   <= grant;
            rr_ptr_q    <= rr_ptr_d;
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Storage carries no reset; only pointers and counts define validity.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_IN; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_entry[i];
      end
   end

   assign out_valid = out_valid_q;
   assign out_src   = out_src_q;
   assign {out_id, out_addr, out_len, out_size, out_burst, out_qos, out_tag} = out_entry_q;

endmodule
